lane_ram_ctrl: RTL and testbench
================================

// Module: lane_ram_ctrl
// PURPOSE
//  Parametrised simple dual-port matrix buffer: one write port, one read port, lane-granular
//  byte enables, configurable read latency with a valid strobe and selectable read-during-write
//  policy. Holds matrix tiles between load and compute stages. A built-in clear sequencer zeroes
//  the array after reset or on request, so consumers never read uninitialised words.
// PARAMETERS
//  ADDR_LEN   10  address width; depth = 2**ADDR_LEN words
//  DATA_LEN   8   bits per lane
//  LANES      4   lanes per word; word width W = LANES*DATA_LEN
//  RD_LAT     1   read latency in cycles, legal 1 or 2 (2 adds an output register stage)
//  RDW_MODE   0   same-address read+write in one cycle: 0 = old data, 1 = new data (write-first)
// PORTS
//  CLK       in   1         clock, rising edge
//  RST_N     in   1         asynchronous active-low reset
//  clr_req   in   1         pulse: start a full-array clear (sampled only in IDLE)
//  ready     out  1         1 = IDLE, ports accepted; 0 = clearing
//  wr_en     in   1         write request, honoured only when ready=1
//  wr_be     in   LANES     per-lane write enable; bit i gates wr_data[i*DATA_LEN +: DATA_LEN]
//  wr_addr   in   ADDR_LEN  write address
//  wr_data   in   W         write data
//  rd_en     in   1         read request, honoured only when ready=1
//  rd_addr   in   ADDR_LEN  read address
//  rd_valid  out  1         Q holds data for a read issued RD_LAT cycles earlier
//  Q         out  W         read data
// BEHAVIOUR
//  - Reset: ready=0, rd_valid=0, Q=0, read pipeline flushed, FSM -> CLEAR, clear pointer=0.
//    Array itself not reset; cleared by the sequencer.
//  - FSM states CLEAR, IDLE.
//    CLEAR: writes 0 to word[ptr] each cycle, ptr++; at ptr=2**ADDR_LEN-1 write then -> IDLE,
//    ready=1 the following cycle. Total clear = 2**ADDR_LEN cycles. wr_en/rd_en/clr_req ignored.
//    IDLE: clr_req=1 -> CLEAR next cycle, ptr=0, ready drops that same next cycle. A wr_en/rd_en in
//    the clr_req cycle is still honoured.
//  - RST_N asserted mid-clear: restart from ptr=0 after release.
//  - Write: ready&wr_en at edge k updates only lanes with wr_be[i]=1; wr_be=0 is a no-op.
//  - Read: ready&rd_en at edge k -> Q valid and rd_valid=1 after edge k+RD_LAT-1 (i.e. visible in
//    cycle k+RD_LAT). rd_valid is a 1-cycle strobe per accepted read; back-to-back reads give
//    back-to-back strobes, one read per cycle throughput.
//  - Q holds last read value when rd_valid=0 (not zeroed).
//  - Reads already in flight when CLEAR starts complete normally with pre-clear data.
//  - Same-address read+write same cycle: RDW_MODE=0 returns pre-write word; RDW_MODE=1 returns
//    written lanes new, unwritten lanes old. Different addresses: independent.
//  - Addresses are full-width; no wrap logic needed, all codes map to a word.
//  - No X on Q/rd_valid after reset under any stimulus.
// TESTING
//  1. Reset release -> ready=0 exactly 2**ADDR_LEN cycles then 1; read all addresses -> Q=0 each.
//  2. Write 0xAABBCCDD @0x005 be=4'b1111, then be=4'b0101 data 0x11223344 -> read 0xAA22CC44.
//  3. RD_LAT=1 and 2: rd_en @addr 3 at cycle t -> rd_valid high only in cycle t+RD_LAT, correct Q;
//     reads on 4 consecutive cycles -> 4 consecutive strobes in order.
//  4. Word@7=0x01010101; same cycle write 0xFFFFFFFF be=4'b0011 and read @7 -> RDW_MODE=0:
//     0x01010101; RDW_MODE=1: 0x0101FFFF.
//  5. Pulse clr_req in IDLE with read in flight -> read returns old data; ready low 2**ADDR_LEN
//     cycles; writes/reads during clear ignored (no rd_valid); afterwards all words 0.
//  6. Drop RST_N halfway through clear -> outputs 0 immediately; clear restarts, full length.

Source files
------------

// File: rtl/lane_ram_ctrl_if.sv
// Write/read/clear port bundle for lane_ram_ctrl.
// master drives requests, slave (the buffer) returns ready and read data.
interface lane_ram_ctrl_if #(
   parameter int unsigned ADDR_LEN = 10,
   parameter int unsigned DATA_LEN = 8,
   parameter int unsigned LANES    = 4
);
   logic                         clr_req;
   logic                         ready;
   logic                         wr_en;
   logic [LANES-1:0]             wr_be;
   logic [ADDR_LEN-1:0]          wr_addr;
   logic [LANES*DATA_LEN-1:0]    wr_data;
   logic                         rd_en;
   logic [ADDR_LEN-1:0]          rd_addr;
   logic                         rd_valid;
   logic [LANES*DATA_LEN-1:0]    Q;

   modport master (
      output clr_req, wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr,
      input  ready, rd_valid, Q
   );

   modport slave (
      input  clr_req, wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr,
      output ready, rd_valid, Q
   );
endinterface

// File: rtl/lane_ram_ctrl.sv
// Simple dual-port lane-masked matrix buffer with a clear sequencer that zeroes
// the array after reset or on request; read latency 1 or 2 with a valid strobe.
module lane_ram_ctrl #(
   parameter int unsigned ADDR_LEN = 10,
   parameter int unsigned DATA_LEN = 8,
   parameter int unsigned LANES    = 4,
   parameter int unsigned RD_LAT   = 1,
   parameter int unsigned RDW_MODE = 0
) (
   input logic              CLK,
   input logic              RST_N,
   lane_ram_ctrl_if.slave   bus
);
   localparam int unsigned W     = LANES * DATA_LEN;
   localparam int unsigned DEPTH = 2 ** ADDR_LEN;

   typedef enum logic {CLEAR, IDLE} state_t;

   state_t              state, state_nx;
   logic [ADDR_LEN-1:0] ptr, ptr_nx;
   logic                ready;

   logic [W-1:0]        mem [DEPTH];
   logic                mem_we;
   logic [ADDR_LEN-1:0] mem_waddr;
   logic [W-1:0]        mem_wdata;
   logic [W-1:0]        mem_wmask;
   logic [W-1:0]        be_mask;

   logic                rd_acc;
   logic [W-1:0]        rd_word;
   logic                q_vld;
   logic [W-1:0]        q_dat;

   always_comb begin
      be_mask = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         be_mask[i*DATA_LEN +: DATA_LEN] = {DATA_LEN{bus.wr_be[i]}};
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= CLEAR;
         ptr   <= '0;
      end else begin
         state <= state_nx;
         ptr   <= ptr_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      ptr_nx    = ptr;
      ready     = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = bus.wr_addr;
      mem_wdata = bus.wr_data;
      mem_wmask = be_mask;
      case (state)
         CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = ptr;
            mem_wdata = '0;
            mem_wmask = '1;
            ptr_nx    = ptr + ADDR_LEN'(1);
            if (ptr == '1) begin
               state_nx = IDLE;
            end
         end
         IDLE: begin
            ready  = 1'b1;
            mem_we = bus.wr_en;
            // Requests in the clr_req cycle are still honoured; only the next cycle clears.
            if (bus.clr_req) begin
               state_nx = CLEAR;
               ptr_nx   = '0;
            end
         end
         default: begin
            state_nx = CLEAR;
            ptr_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (mem_we) begin
         mem[mem_waddr] <= (mem[mem_waddr] & ~mem_wmask) | (mem_wdata & mem_wmask);
      end
   end

   assign rd_acc = ready & bus.rd_en;

   // Write-first mode forwards only the lanes being written at the same address.
   always_comb begin
      rd_word = mem[bus.rd_addr];
      if ((RDW_MODE == 1) && ready && bus.wr_en && (bus.wr_addr == bus.rd_addr)) begin
         rd_word = (rd_word & ~be_mask) | (bus.wr_data & be_mask);
      end
   end

   if (RD_LAT == 2) begin : g_lat2
      logic         s1_vld;
      logic [W-1:0] s1_dat;

      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
            q_vld  <= 1'b0;
            q_dat  <= '0;
         end else begin
            s1_vld <= rd_acc;
            if (rd_acc) begin
               s1_dat <= rd_word;
            end
            q_vld <= s1_vld;
            if (s1_vld) begin
               q_dat <= s1_dat;
            end
         end
      end
   end else begin : g_lat1
      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            q_vld <= 1'b0;
            q_dat <= '0;
         end else begin
            q_vld <= rd_acc;
            if (rd_acc) begin
               q_dat <= rd_word;
            end
         end
      end
   end

   assign bus.ready    = ready;
   assign bus.rd_valid = q_vld;
   assign bus.Q        = q_dat;
endmodule

// File: tb/tb_lane_ram_ctrl.sv
// Scoreboard bench for lane_ram_ctrl: one instance at RD_LAT=1/old-data, one at
// RD_LAT=2/write-first, both fed the same stimulus.
module tb_lane_ram_ctrl;
   localparam int unsigned AL    = 10;
   localparam int unsigned DL    = 8;
   localparam int unsigned NL    = 4;
   localparam int unsigned W     = NL * DL;
   localparam int unsigned DEPTH = 1 << AL;

   typedef struct {
      logic [W-1:0] data;
      int unsigned  due;
      string        tag;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   int unsigned cyc = 0;
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   logic [W-1:0] ref_mem [DEPTH];
   exp_t         q_a[$];
   exp_t         q_b[$];
   exp_t         e;
   logic [W-1:0] last_a = '0;
   logic [W-1:0] last_b = '0;

   lane_ram_ctrl_if #(.ADDR_LEN(AL), .DATA_LEN(DL), .LANES(NL)) bus_a ();
   lane_ram_ctrl_if #(.ADDR_LEN(AL), .DATA_LEN(DL), .LANES(NL)) bus_b ();

   assign bus_b.clr_req = bus_a.clr_req;
   assign bus_b.wr_en   = bus_a.wr_en;
   assign bus_b.wr_be   = bus_a.wr_be;
   assign bus_b.wr_addr = bus_a.wr_addr;
   assign bus_b.wr_data = bus_a.wr_data;
   assign bus_b.rd_en   = bus_a.rd_en;
   assign bus_b.rd_addr = bus_a.rd_addr;

   lane_ram_ctrl #(.ADDR_LEN(AL), .DATA_LEN(DL), .LANES(NL), .RD_LAT(1), .RDW_MODE(0))
      dut_a (.CLK(CLK), .RST_N(RST_N), .bus(bus_a));
   lane_ram_ctrl #(.ADDR_LEN(AL), .DATA_LEN(DL), .LANES(NL), .RD_LAT(2), .RDW_MODE(1))
      dut_b (.CLK(CLK), .RST_N(RST_N), .bus(bus_b));

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Scoreboard side: strobes pop the queue head, Q must hold between strobes.
   always @(negedge CLK) begin
      if (RST_N) begin
         if (bus_a.rd_valid) begin
            if (q_a.size() == 0) check_eq("a_spurious_valid", bus_a.rd_valid, 1'b0);
            else begin
               e = q_a.pop_front();
               check_eq({"a_", e.tag}, bus_a.Q, e.data);
               check_eq({"a_lat_", e.tag}, cyc, e.due);
               last_a = e.data;
            end
         end else begin
            check_eq("a_hold", bus_a.Q, last_a);
            if (q_a.size() != 0 && q_a[0].due <= cyc) begin
               check_eq({"a_missing_", q_a[0].tag}, bus_a.rd_valid, 1'b1);
               void'(q_a.pop_front());
            end
         end
         if (bus_b.rd_valid) begin
            if (q_b.size() == 0) check_eq("b_spurious_valid", bus_b.rd_valid, 1'b0);
            else begin
               e = q_b.pop_front();
               check_eq({"b_", e.tag}, bus_b.Q, e.data);
               check_eq({"b_lat_", e.tag}, cyc, e.due);
               last_b = e.data;
            end
         end else begin
            check_eq("b_hold", bus_b.Q, last_b);
            if (q_b.size() != 0 && q_b[0].due <= cyc) begin
               check_eq({"b_missing_", q_b[0].tag}, bus_b.rd_valid, 1'b1);
               void'(q_b.pop_front());
            end
         end
      end
   end

   task automatic drive(input logic wr, input logic [AL-1:0] wa, input logic [W-1:0] wd,
                        input logic [NL-1:0] be, input logic rd, input logic [AL-1:0] ra,
                        input logic clr);
      bus_a.wr_en   = wr;
      bus_a.wr_addr = wa;
      bus_a.wr_data = wd;
      bus_a.wr_be   = be;
      bus_a.rd_en   = rd;
      bus_a.rd_addr = ra;
      bus_a.clr_req = clr;
   endtask

   // One accepted cycle in IDLE: model the RAM and queue expected read results.
   task automatic op(input logic wr, input logic [AL-1:0] wa, input logic [W-1:0] wd,
                     input logic [NL-1:0] be, input logic rd, input logic [AL-1:0] ra,
                     input logic clr, input string tag);
      logic [W-1:0] mask;
      logic [W-1:0] old;
      exp_t         x;
      mask = '0;
      for (int i = 0; i < int'(NL); i++) if (be[i]) mask[i*DL +: DL] = '1;
      if (rd) begin
         old    = ref_mem[ra];
         x.tag  = tag;
         x.data = old;
         x.due  = cyc + 1;
         q_a.push_back(x);
         x.data = (wr && wa == ra) ? ((old & ~mask) | (wd & mask)) : old;
         x.due  = cyc + 2;
         q_b.push_back(x);
      end
      if (wr) ref_mem[wa] = (ref_mem[wa] & ~mask) | (wd & mask);
      drive(wr, wa, wd, be, rd, ra, clr);
      @(negedge CLK);
      drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
   endtask

   task automatic idle(input int unsigned n);
      drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
      repeat (n) @(negedge CLK);
   endtask

   // Measures how long ready stays low; optionally hammers the ports meanwhile.
   task automatic wait_clear(input bit junk, input string tag);
      int unsigned n, na, nb;
      for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
      check_eq({tag, "_a_low"}, bus_a.ready, 1'b0);
      check_eq({tag, "_b_low"}, bus_b.ready, 1'b0);
      n = 0; na = 0; nb = 0;
      while (!(bus_a.ready && bus_b.ready) && n < DEPTH + 8) begin
         if (junk) drive(1'b1, '0, '1, '1, 1'b1, AL'(5), 1'b1);
         @(negedge CLK);
         n++;
         if (bus_a.ready && na == 0) na = n;
         if (bus_b.ready && nb == 0) nb = n;
      end
      drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
      check_eq({tag, "_a_len"}, na, DEPTH);
      check_eq({tag, "_b_len"}, nb, DEPTH);
   endtask

   task automatic read_all(input string tag);
      for (int i = 0; i < int'(DEPTH); i++) op(1'b0, '0, '0, '0, 1'b1, AL'(i), 1'b0, tag);
      idle(4);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_a_ready"}, bus_a.ready, 1'b0);
      check_eq({tag, "_a_valid"}, bus_a.rd_valid, 1'b0);
      check_eq({tag, "_a_q"}, bus_a.Q, '0);
      check_eq({tag, "_b_ready"}, bus_b.ready, 1'b0);
      check_eq({tag, "_b_valid"}, bus_b.rd_valid, 1'b0);
      check_eq({tag, "_b_q"}, bus_b.Q, '0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
      repeat (3) @(negedge CLK);
      check_reset_outputs("por");
      #2 RST_N = 1'b1;
      wait_clear(1'b0, "por");
      read_all("init_zero");

      // lane-granular writes
      op(1'b1, AL'(5), 32'hAABBCCDD, 4'b1111, 1'b0, '0, 1'b0, "");
      op(1'b1, AL'(5), 32'h11223344, 4'b0101, 1'b0, '0, 1'b0, "");
      op(1'b0, '0, '0, '0, 1'b1, AL'(5), 1'b0, "be_merge");
      op(1'b1, AL'(5), 32'hFFFFFFFF, 4'b0000, 1'b0, '0, 1'b0, "");
      op(1'b0, '0, '0, '0, 1'b1, AL'(5), 1'b0, "be_zero");
      idle(3);

      // latency and back-to-back throughput
      op(1'b1, AL'(3), 32'h0303_0303, 4'b1111, 1'b0, '0, 1'b0, "");
      op(1'b1, AL'(4), 32'h0404_0404, 4'b1111, 1'b0, '0, 1'b0, "");
      op(1'b1, AL'(6), 32'h0606_0606, 4'b1111, 1'b0, '0, 1'b0, "");
      idle(2);
      op(1'b0, '0, '0, '0, 1'b1, AL'(3), 1'b0, "lat_single");
      idle(4);
      op(1'b0, '0, '0, '0, 1'b1, AL'(3), 1'b0, "burst0");
      op(1'b0, '0, '0, '0, 1'b1, AL'(4), 1'b0, "burst1");
      op(1'b0, '0, '0, '0, 1'b1, AL'(5), 1'b0, "burst2");
      op(1'b0, '0, '0, '0, 1'b1, AL'(6), 1'b0, "burst3");
      op(1'b1, AL'(8), 32'h0808_0808, 4'b1111, 1'b1, AL'(3), 1'b0, "diff_addr");
      op(1'b0, '0, '0, '0, 1'b1, AL'(8), 1'b0, "diff_addr_wr");
      idle(4);

      // read-during-write on the same address
      op(1'b1, AL'(7), 32'h01010101, 4'b1111, 1'b0, '0, 1'b0, "");
      op(1'b1, AL'(7), 32'hFFFFFFFF, 4'b0011, 1'b1, AL'(7), 1'b0, "rdw");
      op(1'b0, '0, '0, '0, 1'b1, AL'(7), 1'b0, "rdw_after");
      idle(4);

      // clear request with a read in flight, port activity ignored while clearing
      op(1'b0, '0, '0, '0, 1'b1, AL'(5), 1'b1, "inflight");
      wait_clear(1'b1, "clr");
      read_all("post_clr");

      // reset halfway through a clear restarts it from the beginning
      op(1'b1, AL'(DEPTH - 3), 32'h5A5A_A5A5, 4'b1111, 1'b0, '0, 1'b0, "");
      op(1'b0, '0, '0, '0, 1'b1, AL'(DEPTH - 3), 1'b0, "pre_rst");
      idle(4);
      op(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, "");
      idle(DEPTH / 2);
      check_eq("mid_clr_ready", bus_a.ready, 1'b0);
      #2 RST_N = 1'b0;
      q_a.delete();
      q_b.delete();
      last_a = '0;
      last_b = '0;
      #1 check_reset_outputs("mid_rst");
      repeat (2) @(negedge CLK);
      #2 RST_N = 1'b1;
      wait_clear(1'b0, "rst_mid");
      op(1'b0, '0, '0, '0, 1'b1, AL'(DEPTH - 3), 1'b0, "post_rst_hi");
      op(1'b0, '0, '0, '0, 1'b1, AL'(5), 1'b0, "post_rst_5");
      idle(6);

      check_eq("a_drain", q_a.size(), 0);
      check_eq("b_drain", q_b.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
